gyms16_cpu: RTL and testbench
=============================

// Module: gyms16_cpu
// PURPOSE
//  GYMS-16 top level: 16-bit, 5-stage pipelined (IF/ID/EX/MEM/WB) RISC-style CPU with Harvard instruction/data memories.
//  Self-contained; only clock/reset in and two status flags out.
//  Program is preloaded by backdoor write into the instruction memory array.
// PARAMETERS
//  IM_DEPTH  256  instruction words (16-bit)
//  DM_DEPTH  256  data words (16-bit)
//  NREGS     8    general registers; r0 reads as 0, writes to r0 are ignored
// PORTS
//  clock       in   1  single clock, rising edge
//  reset       in   1  asynchronous, active-low
//  zero_flag   out  1  last retired ALU/load result == 0
//  error_flag  out  1  sticky fault indicator
// BEHAVIOUR
//  Hierarchy (fixed; benches backdoor-load it): datapath instance DATA, instruction memory instance DATA.IM, array DATA.IM.instruction_memory [0:IM_DEPTH-1] of 16 bits.
//  Reset (reset=0) clears: PC=0, all pipeline registers = NOP, regfile = 0, data memory = 0, zero_flag = 0, error_flag = 0, halted = 0.
//  Instruction memory is NOT cleared by reset.
//  Formats: op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0] sign-extended, imm9=[8:0], imm12=[11:0] sign-extended.
//  0000 NOP | 0001 ADD | 0010 SUB | 0011 AND | 0100 OR | 0101 XOR : rd = rs1 op rs2
//  0110 SLL / 0111 SRL: rd = rs1 shifted by rs2[3:0] (logical)
//  1000 ADDI: rd = rs1 + imm6
//  1001 LW: rd = DM[rs1 + imm6]
//  1010 SW: DM[rs1 + imm6] = R[rd]
//  1011 BEQ: if R[rd]==R[rs1] then PC = PC_of_BEQ + 1 + imm6
//  1100 JMP: PC = PC_of_JMP + 1 + imm12
//  1101 LUI: rd = {imm9, 7'b0}
//  1110 SLT: rd = (signed rs1 < signed rs2) ? 1 : 0
//  1111 HALT: when it reaches WB, PC and fetch freeze; pipeline drains; state holds until reset
//  Arithmetic: 16-bit wrap-around; no overflow trap.
//  PC is word-addressed and increments by 1 per fetch.
//  Timing: first fetch of address 0 on the first rising edge after reset deasserts.
//   Ideal CPI = 1; result written to regfile on the WB edge.
//   Regfile writes first half / reads second half: WB->ID same-cycle bypass.
//  Forwarding: EX/MEM and MEM/WB results forward to EX operands; EX/MEM has priority.
//  Load-use hazard: 1 bubble inserted in EX; PC and IF/ID held.
//  Branch/JMP: resolved in EX; if taken, the two younger instructions (IF, ID) are flushed to NOP, giving a 2-cycle penalty.
//   Not-taken: no penalty.
//  zero_flag: updated at WB for ALU ops, ADDI, LUI, SLT and LW; holds for NOP/SW/BEQ/JMP/HALT.
//  error_flag: set at WB, sticky until reset, on either
//   - LW/SW effective address >= DM_DEPTH: access suppressed; LW writes 0;
//   - PC fetch address >= IM_DEPTH: instruction treated as HALT.
//  Reset asserted mid-operation: immediate return to the reset state, aborting in-flight instructions.
//  Backdoor IM writes during or right after reset are legal.
// TESTING
//  1. Reset, load ADDI r1,r0,5; ADDI r2,r0,-5; ADD r3,r1,r2; HALT -> r3=0, zero_flag=1, error_flag=0.
//  2. Back-to-back dependency: ADDI r1,r0,3; ADD r2,r1,r1; SUB r3,r2,r1
//     -> r2=6, r3=3 with no stall (forwarding); retire 1/cycle.
//  3. SW r1 (=7) to DM[4]; LW r4 from DM[4]; ADD r5,r4,r4 -> exactly one bubble; r5=14, zero_flag=0.
//  4. BEQ r0,r0,+2 followed by two ADDI r6 writes -> both skipped (flushed), r6=0, 2-cycle penalty;
//     BEQ not taken -> no penalty.
//  5. LW r1 from address 300 (LUI+ADDI) -> error_flag=1 and stays 1; r1=0; reset clears it.
//  6. Pulse reset low mid-program -> PC=0, flags=0, regfile=0; program re-runs to the same final state; ADD to r0 leaves r0=0.

Source files
------------

// File: rtl/gyms16_cpu.sv
// GYMS-16: 16-bit, 5-stage pipelined CPU.
// Harvard IM/DM, full forwarding, load-use stall, branches resolved in EX.
package gyms16_pkg;
  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic        err;
  } if_id_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        wen;
    logic        err;
  } id_ex_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic        wen;
    logic [15:0] res;
    logic [15:0] sd;
    logic        err;
  } ex_mem_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic        wen;
    logic        zupd;
    logic        halt;
    logic [15:0] res;
    logic        err;
  } mem_wb_t;
endpackage

module gyms16_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);
  logic [15:0] instruction_memory [0:DEPTH-1];

  // spare write port; programs normally arrive by backdoor
  always_ff @(posedge i_clk)
    if (i_we) instruction_memory[i_waddr] <= i_wdata;

  assign o_rdata = instruction_memory[i_raddr];
endmodule

module gyms16_datapath #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_zero,
  output logic o_err
);
  import gyms16_pkg::*;

  localparam int IAW = $clog2(IM_DEPTH);
  localparam int DAW = $clog2(DM_DEPTH);
  localparam logic [15:0] IMD = 16'(IM_DEPTH);
  localparam logic [15:0] DMD = 16'(DM_DEPTH);
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [15:0] r_pc;
  if_id_t      r_ifid, w_ifid;
  id_ex_t      r_idex, w_idex;
  ex_mem_t     r_exmem, w_exmem;
  mem_wb_t     r_memwb, w_memwb;
  logic [15:0] r_rf [0:7];
  logic [15:0] r_dm [0:DM_DEPTH-1];
  logic        r_halted, r_zero, r_err;
  logic [15:0] w_imem;

  gyms16_imem #(.DEPTH(IM_DEPTH)) IM (
    .i_clk  (i_clk),
    .i_we   (1'b0),
    .i_waddr('0),
    .i_wdata('0),
    .i_raddr(r_pc[IAW-1:0]),
    .o_rdata(w_imem)
  );

  logic        w_ferr;
  logic [3:0]  w_op;
  logic [2:0]  w_rd, w_rs1, w_rs2, w_sa, w_sb;
  logic        w_ua, w_ub, w_wr, w_stall;
  logic [15:0] w_imm, w_ra, w_rb;

  assign w_ferr = r_pc >= IMD;
  assign w_op   = r_ifid.ir[15:12];
  assign w_rd   = r_ifid.ir[11:9];
  assign w_rs1  = r_ifid.ir[8:6];
  assign w_rs2  = r_ifid.ir[5:3];

  // fetch: out-of-range PC becomes a faulting HALT
  always_comb begin
    w_ifid.ir  = w_ferr ? {OP_HALT, 12'h000} : w_imem;
    w_ifid.pc  = r_pc;
    w_ifid.err = w_ferr;
  end

  // decode: operand usage, writeback enable, immediate
  always_comb begin
    w_ua  = 1'b0;
    w_ub  = 1'b0;
    w_wr  = 1'b0;
    w_imm = {{10{r_ifid.ir[5]}}, r_ifid.ir[5:0]};
    unique case (1'b1)
      (w_op >= 4'h1 && w_op <= 4'h7),
      (w_op == 4'hE): begin
        w_ua = 1'b1; w_ub = 1'b1; w_wr = 1'b1;
      end
      (w_op == 4'h8),
      (w_op == OP_LW): begin
        w_ua = 1'b1; w_wr = 1'b1;
      end
      (w_op == OP_SW),
      (w_op == OP_BEQ): begin
        w_ua = 1'b1; w_ub = 1'b1;
      end
      (w_op == OP_JMP):
        w_imm = {{4{r_ifid.ir[11]}}, r_ifid.ir[11:0]};
      (w_op == 4'hD): begin
        w_wr  = 1'b1;
        w_imm = {r_ifid.ir[8:0], 7'b0};
      end
      default: ;
    endcase
  end

  // SW/BEQ take their second source from the rd field
  assign w_sa = w_ua ? w_rs1 : 3'd0;
  assign w_sb = !w_ub ? 3'd0 :
    (w_op == OP_SW || w_op == OP_BEQ) ? w_rd : w_rs2;

  assign w_ra = (w_sa == 3'd0) ? 16'd0 :
    (r_memwb.wen && r_memwb.rd == w_sa) ? r_memwb.res : r_rf[w_sa];
  assign w_rb = (w_sb == 3'd0) ? 16'd0 :
    (r_memwb.wen && r_memwb.rd == w_sb) ? r_memwb.res : r_rf[w_sb];

  assign w_stall = r_idex.op == OP_LW && r_idex.wen &&
    (r_idex.rd == w_sa || r_idex.rd == w_sb);

  // ID/EX bundle
  always_comb begin
    w_idex.op  = w_op;
    w_idex.rd  = w_rd;
    w_idex.sa  = w_sa;
    w_idex.sb  = w_sb;
    w_idex.a   = w_ra;
    w_idex.b   = w_rb;
    w_idex.imm = w_imm;
    w_idex.pc  = r_ifid.pc;
    w_idex.wen = w_wr && (w_rd != 3'd0);
    w_idex.err = r_ifid.err;
  end

  logic [15:0] w_fa, w_fb, w_alu, w_addr, w_tgt;
  logic        w_taken, w_aerr, w_mem;

  assign w_fa =
    (r_exmem.wen && r_exmem.rd == r_idex.sa) ? r_exmem.res :
    (r_memwb.wen && r_memwb.rd == r_idex.sa) ? r_memwb.res : r_idex.a;
  assign w_fb =
    (r_exmem.wen && r_exmem.rd == r_idex.sb) ? r_exmem.res :
    (r_memwb.wen && r_memwb.rd == r_idex.sb) ? r_memwb.res : r_idex.b;

  assign w_addr  = w_fa + r_idex.imm;
  assign w_tgt   = r_idex.pc + 16'd1 + r_idex.imm;
  assign w_mem   = r_idex.op == OP_LW || r_idex.op == OP_SW;
  assign w_aerr  = w_mem && (w_addr >= DMD);
  assign w_taken = (r_idex.op == OP_BEQ && w_fa == w_fb) ||
                   r_idex.op == OP_JMP;

  // execute
  always_comb begin
    w_alu = '0;
    unique case (r_idex.op)
      4'h1:    w_alu = w_fa + w_fb;
      4'h2:    w_alu = w_fa - w_fb;
      4'h3:    w_alu = w_fa & w_fb;
      4'h4:    w_alu = w_fa | w_fb;
      4'h5:    w_alu = w_fa ^ w_fb;
      4'h6:    w_alu = w_fa << w_fb[3:0];
      4'h7:    w_alu = w_fa >> w_fb[3:0];
      4'h8, OP_LW, OP_SW:
               w_alu = w_addr;
      4'hD:    w_alu = r_idex.imm;
      4'hE:    w_alu = {15'd0, $signed(w_fa) < $signed(w_fb)};
      default: w_alu = '0;
    endcase
    w_exmem.op  = r_idex.op;
    w_exmem.rd  = r_idex.rd;
    w_exmem.wen = r_idex.wen;
    w_exmem.res = w_alu;
    w_exmem.sd  = w_fb;
    w_exmem.err = r_idex.err | w_aerr;
  end

  // memory access; faulting loads return 0
  always_comb begin
    w_memwb.rd   = r_exmem.rd;
    w_memwb.wen  = r_exmem.wen;
    w_memwb.zupd = r_exmem.op inside {[4'h1:4'h9], 4'hD, 4'hE};
    w_memwb.halt = r_exmem.op == OP_HALT;
    w_memwb.err  = r_exmem.err;
    w_memwb.res  = r_exmem.res;
    if (r_exmem.op == OP_LW)
      w_memwb.res = r_exmem.err ? 16'd0 : r_dm[r_exmem.res[DAW-1:0]];
  end

  // PC and pipeline registers: stall, flush, halt freeze
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= '0;
      r_ifid  <= '0;
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      if (!r_halted) begin
        if (w_taken)       r_pc <= w_tgt;
        else if (!w_stall) r_pc <= r_pc + 16'd1;
      end
      if (w_taken || r_halted) r_ifid <= '0;
      else if (!w_stall)       r_ifid <= w_ifid;
      r_idex  <= (w_taken || w_stall) ? '0 : w_idex;
      r_exmem <= w_exmem;
      r_memwb <= w_memwb;
    end
  end

  // register file write at WB
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (r_memwb.wen) begin
      r_rf[r_memwb.rd] <= r_memwb.res;
    end
  end

  // data memory write at MEM, suppressed on address fault
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DM_DEPTH; i++) r_dm[i] <= '0;
    end else if (r_exmem.op == OP_SW && !r_exmem.err) begin
      r_dm[r_exmem.res[DAW-1:0]] <= r_exmem.sd;
    end
  end

  // retire-time status: zero, sticky error, halt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (r_memwb.zupd) r_zero   <= r_memwb.res == 16'd0;
      if (r_memwb.err)  r_err    <= 1'b1;
      if (r_memwb.halt) r_halted <= 1'b1;
    end
  end

  assign o_zero = r_zero;
  assign o_err  = r_err;
endmodule

module gyms16_cpu #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic clock,
  input  logic reset,
  output logic zero_flag,
  output logic error_flag
);
  gyms16_datapath #(
    .IM_DEPTH(IM_DEPTH),
    .DM_DEPTH(DM_DEPTH)
  ) DATA (
    .i_clk  (clock),
    .i_rst_n(reset),
    .o_zero (zero_flag),
    .o_err  (error_flag)
  );
endmodule

// File: tb/tb_gyms16_cpu.sv
// Directed bench for gyms16_cpu.
// Programs are backdoor-loaded; results read from regfile/DM/flags.
module tb_gyms16_cpu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic zero_flag, error_flag;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] prog [$];

  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] SUB  = 4'h2;
  localparam logic [3:0] ADDI = 4'h8;
  localparam logic [3:0] LW   = 4'h9;
  localparam logic [3:0] SW   = 4'hA;
  localparam logic [3:0] BEQ  = 4'hB;
  localparam logic [15:0] HALT = 16'hF000;

  gyms16_cpu dut (
    .clock     (clock),
    .reset     (reset),
    .zero_flag (zero_flag),
    .error_flag(error_flag)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rr(
    input logic [3:0] op, input logic [2:0] d, a, b);
    return {op, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ri(
    input logic [3:0] op, input logic [2:0] d, a, input int imm);
    return {op, d, a, 6'(imm)};
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_im();
    for (int i = 0; i < 256; i++)
      dut.DATA.IM.instruction_memory[i] = 16'h0000;
    foreach (prog[i])
      dut.DATA.IM.instruction_memory[i] = prog[i];
  endtask

  task automatic restart();
    @(negedge clock);
    reset = 1'b0;
    load_im();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // edges from reset release until HALT retires
  task automatic run(input string tag, input int exp_cyc);
    int cyc = 0;
    while (dut.DATA.r_halted !== 1'b1 && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk(tag, 16'(cyc), 16'(exp_cyc));
  endtask

  initial begin
    // reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_pc",   dut.DATA.r_pc, 16'h0000);
    chk("rst_zero", {15'd0, zero_flag}, 16'h0000);
    chk("rst_err",  {15'd0, error_flag}, 16'h0000);
    chk("rst_halt", {15'd0, dut.DATA.r_halted}, 16'h0000);
    chk("rst_r3",   dut.DATA.r_rf[3], 16'h0000);
    reset = 1'b1;

    // 1: 5 + (-5) = 0
    prog = '{ri(ADDI, 3'd1, 3'd0, 5), ri(ADDI, 3'd2, 3'd0, -5),
             rr(ADD, 3'd3, 3'd1, 3'd2), HALT};
    restart();
    run("t1_cyc", 8);
    chk("t1_r1", dut.DATA.r_rf[1], 16'h0005);
    chk("t1_r2", dut.DATA.r_rf[2], 16'hFFFB);
    chk("t1_r3", dut.DATA.r_rf[3], 16'h0000);
    chk("t1_zero", {15'd0, zero_flag}, 16'h0001);
    chk("t1_err", {15'd0, error_flag}, 16'h0000);

    // 2: back-to-back forwarding, no stall
    prog = '{ri(ADDI, 3'd1, 3'd0, 3), rr(ADD, 3'd2, 3'd1, 3'd1),
             rr(SUB, 3'd3, 3'd2, 3'd1), HALT};
    restart();
    run("t2_cyc", 8);
    chk("t2_r2", dut.DATA.r_rf[2], 16'h0006);
    chk("t2_r3", dut.DATA.r_rf[3], 16'h0003);
    chk("t2_zero", {15'd0, zero_flag}, 16'h0000);

    // 3: store/load, load-use bubble
    prog = '{ri(ADDI, 3'd1, 3'd0, 7), ri(SW, 3'd1, 3'd0, 4),
             ri(LW, 3'd4, 3'd0, 4), rr(ADD, 3'd5, 3'd4, 3'd4), HALT};
    restart();
    run("t3_cyc", 10);
    chk("t3_dm4", dut.DATA.r_dm[4], 16'h0007);
    chk("t3_r4", dut.DATA.r_rf[4], 16'h0007);
    chk("t3_r5", dut.DATA.r_rf[5], 16'h000E);
    chk("t3_zero", {15'd0, zero_flag}, 16'h0000);

    // 4a: taken BEQ flushes two ADDIs
    prog = '{ri(BEQ, 3'd0, 3'd0, 2), ri(ADDI, 3'd6, 3'd0, 1),
             ri(ADDI, 3'd6, 3'd6, 2), ri(ADDI, 3'd7, 3'd0, 9), HALT};
    restart();
    run("t4a_cyc", 9);
    chk("t4a_r6", dut.DATA.r_rf[6], 16'h0000);
    chk("t4a_r7", dut.DATA.r_rf[7], 16'h0009);

    // 4b: JMP +1 skips one, 2-cycle penalty
    prog = '{16'hC001, ri(ADDI, 3'd6, 3'd0, 5),
             ri(ADDI, 3'd7, 3'd0, 2), HALT};
    restart();
    run("t4b_cyc", 9);
    chk("t4b_r6", dut.DATA.r_rf[6], 16'h0000);
    chk("t4b_r7", dut.DATA.r_rf[7], 16'h0002);

    // 4c: BEQ not taken, no penalty
    prog = '{ri(ADDI, 3'd1, 3'd0, 1), ri(BEQ, 3'd1, 3'd0, 2),
             ri(ADDI, 3'd6, 3'd0, 1), ri(ADDI, 3'd6, 3'd6, 2), HALT};
    restart();
    run("t4c_cyc", 9);
    chk("t4c_r6", dut.DATA.r_rf[6], 16'h0003);
    chk("t4c_zero", {15'd0, zero_flag}, 16'h0000);

    // 5: LW from 300 faults
    prog = '{16'hD402, ri(ADDI, 3'd2, 3'd2, 22),
             ri(ADDI, 3'd1, 3'd0, 9), ri(LW, 3'd1, 3'd2, 22), HALT};
    restart();
    run("t5_cyc", 9);
    chk("t5_r2", dut.DATA.r_rf[2], 16'h0116);
    chk("t5_r1", dut.DATA.r_rf[1], 16'h0000);
    chk("t5_err", {15'd0, error_flag}, 16'h0001);
    chk("t5_zero", {15'd0, zero_flag}, 16'h0001);
    repeat (5) @(posedge clock);
    #1;
    chk("t5_sticky", {15'd0, error_flag}, 16'h0001);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_rst_err", {15'd0, error_flag}, 16'h0000);
    chk("t5_rst_r2", dut.DATA.r_rf[2], 16'h0000);

    // 6: mid-program reset, then rerun
    prog = '{ri(ADDI, 3'd1, 3'd0, 4), ri(ADDI, 3'd5, 3'd0, 0),
             ri(ADDI, 3'd2, 3'd0, 6), rr(ADD, 3'd0, 3'd1, 3'd2),
             rr(ADD, 3'd3, 3'd1, 3'd2), ri(SW, 3'd3, 3'd0, 5), HALT};
    restart();
    repeat (6) @(posedge clock);
    #1;
    chk("t6_pre_r1", dut.DATA.r_rf[1], 16'h0004);
    chk("t6_pre_zero", {15'd0, zero_flag}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    chk("t6_mid_pc", dut.DATA.r_pc, 16'h0000);
    chk("t6_mid_zero", {15'd0, zero_flag}, 16'h0000);
    chk("t6_mid_r1", dut.DATA.r_rf[1], 16'h0000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    run("t6_cyc", 11);
    chk("t6_r3", dut.DATA.r_rf[3], 16'h000A);
    chk("t6_r0", dut.DATA.r_rf[0], 16'h0000);
    chk("t6_dm5", dut.DATA.r_dm[5], 16'h000A);
    chk("t6_zero", {15'd0, zero_flag}, 16'h0000);
    chk("t6_err", {15'd0, error_flag}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
